// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor controller.
package serial_sub_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle between a requester and the serial subtractor.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );

endinterface

// File: rtl/sub_bit_slice.sv
// One-bit full subtractor built from two cascaded half-subtract stages.
module sub_bit_slice (
  input  logic a_i,
  input  logic b_i,
  input  logic borrow_in,
  output logic d,
  output logic borrow
);

  logic d_h0;
  logic brw_h0;
  logic brw_h1;

  // First half-subtract: a - b; second: (a - b) - borrow_in.
  assign d_h0   = a_i ^ b_i;
  assign brw_h0 = ~a_i & b_i;
  assign d      = d_h0 ^ borrow_in;
  assign brw_h1 = ~d_h0 & borrow_in;
  assign borrow = brw_h0 | brw_h1;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Sequences one subtract bit-slice over WIDTH cycles, LSB first, to form a - b.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_sub_ctrl_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_sub_ctrl: WIDTH out of range");
  end

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] d_msb;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             bit_d;
  logic             bit_brw;
  logic             last_bit;

  sub_bit_slice u_slice (
    .a_i       (a_sh[0]),
    .b_i       (b_sh[0]),
    .borrow_in (brw),
    .d         (bit_d),
    .borrow    (bit_brw)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // Result bits enter at the MSB so the LSB-first stream lands in place.
  always_comb begin
    d_msb            = '0;
    d_msb[WIDTH-1]   = bit_d;
    res_nxt          = (res_sh >> 1) | d_msb;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = bus.start ? RUN : IDLE;
      RUN:     state_nxt = last_bit ? DONE : RUN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      brw      <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            brw  <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt;
          brw    <= bit_brw;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            diff_q   <= res_nxt;
            borrow_q <= bit_brw;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomized self-checking bench for serial_sub_ctrl (WIDTH=8 and WIDTH=1 builds).
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(8)) if8 ();
  serial_sub_ctrl_if #(.WIDTH(1)) if1 ();

  serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_sub_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Reference model: ph = edges since acceptance (0 idle, 1..w busy, w+1 done).
  int          ph [2] = '{0, 0};
  longint      pa [2] = '{0, 0};
  longint      pb [2] = '{0, 0};
  logic [31:0] md [2] = '{32'd0, 32'd0};
  logic        mb [2] = '{1'b0, 1'b0};

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input int w, input logic st,
                            input logic [31:0] av, input logic [31:0] bv);
    if (rst) begin
      ph[i] = 0; md[i] = '0; mb[i] = 1'b0;
    end else if (ph[i] == 0) begin
      if (st === 1'b1) begin
        ph[i] = 1; pa[i] = longint'(av); pb[i] = longint'(bv);
      end
    end else if (ph[i] < w) begin
      ph[i]++;
    end else if (ph[i] == w) begin
      ph[i] = w + 1;
      md[i] = 32'((pa[i] - pb[i]) & ((longint'(1) << w) - 1));
      mb[i] = (pa[i] < pb[i]);
    end else begin
      ph[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 8, if8.start, {24'd0, if8.a}, {24'd0, if8.b});
    model_step(1, 1, if1.start, {31'd0, if1.a}, {31'd0, if1.b});
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy8",   if8.busy,       (ph[0] >= 1 && ph[0] <= 8));
      check("done8",   if8.done,       (ph[0] == 9));
      check("diff8",   if8.diff,       md[0]);
      check("borrow8", if8.borrow_out, mb[0]);
      check("busy1",   if1.busy,       (ph[1] == 1));
      check("done1",   if1.done,       (ph[1] == 2));
      check("diff1",   if1.diff,       md[1]);
      check("borrow1", if1.borrow_out, mb[1]);
    end
  end

  task automatic wait_idle8();
    int k;
    k = 0;
    while ((if8.busy !== 1'b0 || if8.done !== 1'b0) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) check("idle8_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] exp_d, input logic exp_b);
    int lat;
    wait_idle8();
    if8.start = 1'b1; if8.a = av; if8.b = bv;
    @(negedge clk);
    if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom);
    lat = 1;
    while (if8.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      if8.a = 8'($urandom); if8.b = 8'($urandom);
      lat++;
    end
    check("latency8", lat, 9);
    check("op_diff", if8.diff, exp_d);
    check("op_borrow", if8.borrow_out, exp_b);
    @(negedge clk);
    check("hold_diff", if8.diff, exp_d);
    check("hold_borrow", if8.borrow_out, exp_b);
    check("done_pulse", if8.done, 1'b0);
  endtask

  initial begin
    if8.start = 1'b1; if8.a = 8'd55; if8.b = 8'd3;
    if1.start = 1'b1; if1.a = 1'b1; if1.b = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", if8.busy, 1'b0);
    check("rst_done", if8.done, 1'b0);
    check("rst_diff", if8.diff, 8'd0);
    check("rst_borrow", if8.borrow_out, 1'b0);
    rst = 1'b0; if8.start = 1'b0; if1.start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", if8.busy, 1'b0);

    do_op(8'd100, 8'd37, 8'd63, 1'b0);
    do_op(8'd5, 8'd9, 8'hFC, 1'b1);
    do_op(8'h00, 8'hFF, 8'h01, 1'b1);
    do_op(8'hAA, 8'hAA, 8'h00, 1'b0);

    // start held high, operands churn every cycle
    wait_idle8();
    if8.start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      if8.a = 8'($urandom); if8.b = 8'($urandom);
      @(negedge clk);
    end
    if8.start = 1'b0;

    // reset during the third RUN cycle
    do_op(8'd9, 8'd2, 8'd7, 1'b0);
    wait_idle8();
    if8.start = 1'b1; if8.a = 8'd77; if8.b = 8'd13;
    @(negedge clk);
    if8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", if8.busy, 1'b0);
    check("midrst_done", if8.done, 1'b0);
    check("midrst_diff", if8.diff, 8'd0);
    check("midrst_borrow", if8.borrow_out, 1'b0);
    do_op(8'd200, 8'd1, 8'd199, 1'b0);

    // WIDTH=1 truth table
    for (int p = 0; p < 4; p++) begin
      logic [1:0] pr;
      logic [1:0] ex;
      pr = 2'(p);
      ex = (p == 0) ? 2'b00 : (p == 1) ? 2'b11 : (p == 2) ? 2'b10 : 2'b00;
      @(negedge clk); @(negedge clk); @(negedge clk);
      if1.start = 1'b1; if1.a = pr[1]; if1.b = pr[0];
      @(negedge clk);
      if1.start = 1'b0;
      check("w1_busy", if1.busy, 1'b1);
      @(negedge clk);
      check("w1_done", if1.done, 1'b1);
      check("w1_diff", if1.diff, ex[1]);
      check("w1_borrow", if1.borrow_out, ex[0]);
    end

    // random traffic on both builds, occasional reset
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 99) == 0);
      if8.start = ($urandom_range(0, 3) == 0);
      if8.a     = 8'($urandom);
      if8.b     = 8'($urandom);
      if1.start = ($urandom_range(0, 2) == 0);
      if1.a     = 1'($urandom);
      if1.b     = 1'($urandom);
    end
    rst = 1'b0; if8.start = 1'b0; if1.start = 1'b0;
    repeat (12) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
